hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Stall/flush controller of the 5-stage RISC-V pipeline; the counterpart of operand forwarding: it handles
//  every hazard that forwarding cannot resolve. Detects load-use hazards, branch redirects and dependencies
//  on the multi-cycle divider, using a per-register pending scoreboard. Drives StallF/StallD/FlushD/FlushE.
//  Also keeps a stall-cycle perf counter and a sticky stall-timeout flag.
// PARAMETERS
//  NREG        32  architectural registers (x0 hard-wired zero)
//  AW          5   register index width, clog2(NREG)
//  CNT_W       16  stall perf counter width (saturating)
//  TIMEOUT     64  consecutive stall cycles before HazardTimeout sets
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  Rs1_D,Rs2_D  in   AW     source regs of instr in Decode
//  RD_D         in   AW     dest reg of instr in Decode
//  RegWriteD    in   1      Decode instr writes RD_D
//  DivOpD       in   1      Decode instr is DIV/REM
//  RD_E         in   AW     dest reg of instr in Execute
//  RegWriteE    in   1      Execute instr writes RD_E
//  ResultSrcE0  in   1      Execute instr is a load
//  DivOpE       in   1      Execute instr issues to divider this cycle
//  PCSrcE       in   1      taken branch/jump resolved in Execute
//  DivDoneW     in   1      divider result written back this cycle
//  DivRdW       in   AW     dest reg of that result
//  StallF,StallD out 1      hold PC / IF-ID register
//  FlushD,FlushE out 1      bubble IF-ID / ID-EX register
//  DivBusy      out  1      divider operation outstanding (registered)
//  StallCount   out  CNT_W  cycles with StallD=1 since reset, saturates at all-ones
//  HazardTimeout out 1      sticky: StallD held >= TIMEOUT consecutive cycles
// BEHAVIOUR
//  Reset (async, rst=1): pending[]=0, DivBusy=0, StallCount=0, run counter=0, HazardTimeout=0;
//   StallF/StallD/FlushD/FlushE forced 0 while rst=1.
//  Combinational terms (same cycle, zero latency):
//   lwStall  = ResultSrcE0 & RegWriteE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D)
//   sbStall  = (pend(Rs1_D) | pend(Rs2_D) | (RegWriteD & pend(RD_D)))   ; pend(0)=0; WAW included
//   divStall = DivOpD & DivBusy & ~DivDoneW                             ; one divide in flight max
//   stall    = lwStall | sbStall | divStall
//   pend(r)  = pending[r] & ~(DivDoneW & DivRdW==r)                     ; W-clear bypass
//  Outputs: StallF=StallD= stall & ~PCSrcE; FlushD=PCSrcE; FlushE= stall | PCSrcE.
//   Taken branch wins over every stall: Decode instr is wrong-path, PC must load the target.
//  Scoreboard (registered): set pending[RD_E] when DivOpE & RegWriteE & RD_E!=0;
//   clear pending[DivRdW] when DivDoneW. Same reg set+clear same cycle -> set wins. x0 never set.
//  Divider occupancy FSM: IDLE -(DivOpE)-> BUSY -(DivDoneW & ~DivOpE)-> IDLE;
//   BUSY & DivDoneW & DivOpE -> stays BUSY (back-to-back). DivBusy = (state==BUSY).
//   DivDoneW while IDLE: ignored for FSM, scoreboard clear still applied.
//  Perf: StallCount += 1 each cycle StallD=1, holds at 2^CNT_W-1. Run counter counts consecutive
//   StallD=1 cycles, cleared on any StallD=0 cycle, saturates at TIMEOUT; HazardTimeout sets when
//   run counter reaches TIMEOUT, cleared only by rst.
//  Reset mid-stall/mid-divide: all state dropped immediately; in-flight divide result is discarded by
//   pipeline reset, not by this block.
// STRUCTURE
//  Package riscv_pkg: REG_ZERO constant, AW/NREG, ResultSrc encoding (bit0 = load).
//  Sub-module hazard_scoreboard: NREG-bit pending vector, set/clear ports, two bypassed read ports + one
//   WAW read port. Top holds detection logic, divider FSM, perf/timeout counters.
// TESTING
//  Load x5 in E, D reads x5 as Rs2 -> StallF=StallD=FlushE=1 for 1 cycle; RD_E=0 -> no stall.
//  DIV x7 issues (DivOpE=1,RD_E=7); next cycle Rs1_D=7 -> stall until DivDoneW&DivRdW=7 cycle, which releases same cycle.
//  DivBusy=1, DivOpD=1 -> StallD=1; DivDoneW=1 that cycle -> StallD=0, DivBusy stays 1 after DivOpE.
//  lwStall=1 and PCSrcE=1 together -> StallF=StallD=0, FlushD=FlushE=1.
//  Hold sbStall 64 cycles (TIMEOUT=64) -> HazardTimeout=1 at 64th cycle, stays 1 after stall ends; StallCount=64.
//  Assert rst during BUSY with pending[7]=1 -> DivBusy=0, all outputs 0, Rs1_D=7 no longer stalls.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline constants and types used by the hazard/stall control logic.
package riscv_pkg;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // ResultSrc encoding: bit 0 set means the instruction is a load.
  localparam int RESULT_SRC_LOAD_BIT = 0;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for results still owed by the multi-cycle divider.
module hazard_scoreboard
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd1_idx,
  input  logic [AW-1:0] rd2_idx,
  input  logic [AW-1:0] rd3_idx,
  output logic          rd1_pend,
  output logic          rd2_pend,
  output logic          rd3_pend
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_idx != REG_ZERO) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Clear is applied first so a same-cycle set on the same register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  // A write-back landing this cycle releases the reader immediately.
  function automatic logic pend_rd(input logic [AW-1:0] idx);
    return (idx != REG_ZERO) && pending[idx] && !(clr_en && clr_idx == idx);
  endfunction

  assign rd1_pend = pend_rd(rd1_idx);
  assign rd2_pend = pend_rd(rd2_idx);
  assign rd3_pend = pend_rd(rd3_idx);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use, divider-dependency and branch-redirect hazards,
// plus a saturating stall counter and a sticky stall-timeout flag.
module hazard_unit
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    Rs1_D,
  input  logic [AW-1:0]    Rs2_D,
  input  logic [AW-1:0]    RD_D,
  input  logic             RegWriteD,
  input  logic             DivOpD,
  input  logic [AW-1:0]    RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE0,
  input  logic             DivOpE,
  input  logic             PCSrcE,
  input  logic             DivDoneW,
  input  logic [AW-1:0]    DivRdW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             DivBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic             HazardTimeout,
  output div_state_e       DivState
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);

  logic             rs1_pend, rs2_pend, rd_pend;
  logic             lw_stall, sb_stall, div_stall, stall;
  logic [RUN_W-1:0] run_cnt;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (DivOpE & RegWriteE),
    .set_idx  (RD_E),
    .clr_en   (DivDoneW),
    .clr_idx  (DivRdW),
    .rd1_idx  (Rs1_D),
    .rd2_idx  (Rs2_D),
    .rd3_idx  (RD_D),
    .rd1_pend (rs1_pend),
    .rd2_pend (rs2_pend),
    .rd3_pend (rd_pend)
  );

  assign lw_stall  = ResultSrcE0 & RegWriteE & (RD_E != REG_ZERO) &
                     ((RD_E == Rs1_D) | (RD_E == Rs2_D));
  assign sb_stall  = rs1_pend | rs2_pend | (RegWriteD & rd_pend);
  assign div_stall = DivOpD & DivBusy & ~DivDoneW;
  assign stall     = lw_stall | sb_stall | div_stall;

  // A taken branch overrides any stall: the Decode instruction is wrong-path.
  assign StallF = ~rst & stall & ~PCSrcE;
  assign StallD = ~rst & stall & ~PCSrcE;
  assign FlushD = ~rst & PCSrcE;
  assign FlushE = ~rst & (stall | PCSrcE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DivState <= DIV_IDLE;
      DivBusy  <= 1'b0;
    end else begin
      case (DivState)
        DIV_IDLE: if (DivOpE) begin
          DivState <= DIV_BUSY;
          DivBusy  <= 1'b1;
        end
        DIV_BUSY: if (DivDoneW && !DivOpE) begin
          DivState <= DIV_IDLE;
          DivBusy  <= 1'b0;
        end
        default: begin
          DivState <= DIV_IDLE;
          DivBusy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount    <= '0;
      run_cnt       <= '0;
      HazardTimeout <= 1'b0;
    end else if (StallD) begin
      if (StallCount != '1) StallCount <= StallCount + CNT_W'(1);
      if (run_cnt != RUN_W'(TIMEOUT)) run_cnt <= run_cnt + RUN_W'(1);
      if (run_cnt == RUN_W'(TIMEOUT - 1)) HazardTimeout <= 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random traffic
// against an independent cycle model feeding an expected-value queue.
module tb_hazard_unit;
  import riscv_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    Rs1_D, Rs2_D, RD_D, RD_E, DivRdW;
  logic             RegWriteD, DivOpD, RegWriteE, ResultSrcE0, DivOpE, PCSrcE, DivDoneW;
  logic             StallF, StallD, FlushD, FlushE, DivBusy, HazardTimeout;
  logic [CNT_W-1:0] StallCount;
  div_state_e       DivState;

  hazard_unit dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_D(RD_D),
    .RegWriteD(RegWriteD), .DivOpD(DivOpD), .RD_E(RD_E), .RegWriteE(RegWriteE),
    .ResultSrcE0(ResultSrcE0), .DivOpE(DivOpE), .PCSrcE(PCSrcE),
    .DivDoneW(DivDoneW), .DivRdW(DivRdW), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .DivBusy(DivBusy), .StallCount(StallCount),
    .HazardTimeout(HazardTimeout), .DivState(DivState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] exp_q[$];

  // reference model state
  bit m_pend[NREG];
  bit m_busy;
  int m_cnt, m_run;
  bit m_to;
  bit m_stall_d;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend_rd(input logic [AW-1:0] r);
    return (r != 0) && m_pend[r] && !(DivDoneW && DivRdW == r);
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = 0; m_cnt = 0; m_run = 0; m_to = 0;
  endtask

  task automatic idle_inputs();
    Rs1_D = 0; Rs2_D = 0; RD_D = 0; RegWriteD = 0; DivOpD = 0;
    RD_E = 0; RegWriteE = 0; ResultSrcE0 = 0; DivOpE = 0; PCSrcE = 0;
    DivDoneW = 0; DivRdW = 0;
  endtask

  // Drive phase already done by caller; predict, wait to mid-cycle, compare.
  task automatic cycle_begin();
    bit lw, sb, dv, st, sf, fd, fe;
    logic [21:0] exp_v, got_v;
    if (rst) model_reset();
    lw = ResultSrcE0 && RegWriteE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    sb = m_pend_rd(Rs1_D) || m_pend_rd(Rs2_D) || (RegWriteD && m_pend_rd(RD_D));
    dv = DivOpD && m_busy && !DivDoneW;
    st = lw || sb || dv;
    sf = !rst && st && !PCSrcE;
    fd = !rst && PCSrcE;
    fe = !rst && (st || PCSrcE);
    m_stall_d = sf;
    exp_q.push_back({sf, sf, fd, fe, m_busy, m_to, m_cnt[15:0]});
    @(negedge clk);
    got_v = {StallF, StallD, FlushD, FlushE, DivBusy, HazardTimeout, StallCount};
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL queue: got empty expected entry");
    end else begin
      exp_v = exp_q.pop_front();
      check_val("vec", {10'd0, got_v}, {10'd0, exp_v});
    end
  endtask

  // Advance the model across the rising edge, then return to the drive point.
  task automatic cycle_end();
    if (!rst) begin
      if (DivDoneW) m_pend[DivRdW] = 1'b0;
      if (DivOpE && RegWriteE && RD_E != 0) m_pend[RD_E] = 1'b1;
      if (!m_busy && DivOpE) m_busy = 1;
      else if (m_busy && DivDoneW && !DivOpE) m_busy = 0;
      if (m_stall_d) begin
        if (m_cnt != 65535) m_cnt++;
        if (m_run < TIMEOUT) m_run++;
        if (m_run == TIMEOUT) m_to = 1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cycle_begin();
    cycle_end();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue_div(input logic [AW-1:0] rd);
    idle_inputs();
    DivOpE = 1; RegWriteE = 1; RD_E = rd;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // reset state
    cycle_begin();
    check_val("rst_cnt", 32'(StallCount), 32'd0);
    check_val("rst_busy", 32'(DivBusy), 32'd0);
    cycle_end();

    // load-use on Rs2, then same with RD_E = x0
    idle_inputs();
    RegWriteE = 1; ResultSrcE0 = 1; RD_E = 5; Rs2_D = 5;
    cycle_begin();
    check_val("lw_stall_d", 32'(StallD), 32'd1);
    check_val("lw_flush_e", 32'(FlushE), 32'd1);
    cycle_end();
    RD_E = 0; Rs2_D = 0;
    cycle_begin();
    check_val("lw_x0", 32'(StallD), 32'd0);
    cycle_end();

    // divide to x7, consumer stalls until the write-back cycle
    issue_div(7);
    Rs1_D = 7;
    for (int i = 0; i < 3; i++) begin
      cycle_begin();
      check_val("div_dep", 32'(StallD), 32'd1);
      cycle_end();
    end
    DivDoneW = 1; DivRdW = 7;
    cycle_begin();
    check_val("div_release", 32'(StallD), 32'd0);
    cycle_end();

    // second divide blocked by busy divider, released on done with back-to-back issue
    issue_div(3);
    DivOpD = 1;
    cycle_begin();
    check_val("div_busy_stall", 32'(StallD), 32'd1);
    cycle_end();
    DivOpD = 1; DivDoneW = 1; DivRdW = 3; DivOpE = 1; RegWriteE = 1; RD_E = 4;
    cycle_begin();
    check_val("div_done_free", 32'(StallD), 32'd0);
    cycle_end();
    idle_inputs();
    cycle_begin();
    check_val("b2b_busy", 32'(DivBusy), 32'd1);
    cycle_end();
    DivDoneW = 1; DivRdW = 4;
    step();

    // taken branch beats load-use
    idle_inputs();
    RegWriteE = 1; ResultSrcE0 = 1; RD_E = 5; Rs1_D = 5; PCSrcE = 1;
    cycle_begin();
    check_val("br_stall_f", 32'(StallF), 32'd0);
    check_val("br_stall_d", 32'(StallD), 32'd0);
    check_val("br_flush", 32'({FlushD, FlushE}), 32'd3);
    cycle_end();

    // timeout after 64 consecutive scoreboard stalls
    do_reset();
    issue_div(7);
    Rs1_D = 7;
    for (int i = 0; i < TIMEOUT; i++) begin
      cycle_begin();
      if (i == TIMEOUT - 1) check_val("to_early", 32'(HazardTimeout), 32'd0);
      cycle_end();
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      cycle_begin();
      check_val("to_sticky", 32'(HazardTimeout), 32'd1);
      check_val("to_count", 32'(StallCount), 32'd64);
      cycle_end();
    end

    // reset while the divider is busy with x7 pending
    issue_div(7);
    Rs1_D = 7; PCSrcE = 1; rst = 1'b1;
    cycle_begin();
    check_val("rst_outs", 32'({StallF, StallD, FlushD, FlushE, DivBusy}), 32'd0);
    cycle_end();
    rst = 1'b0; PCSrcE = 0;
    cycle_begin();
    check_val("rst_no_pend", 32'(StallD), 32'd0);
    cycle_end();

    // random traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      Rs1_D       = AW'($urandom_range(0, 7));
      Rs2_D       = AW'($urandom_range(0, 7));
      RD_D        = AW'($urandom_range(0, 7));
      RegWriteD   = 1'($urandom_range(0, 1));
      DivOpD      = ($urandom_range(0, 3) == 0);
      RD_E        = AW'($urandom_range(0, 7));
      RegWriteE   = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 3) == 0);
      DivOpE      = ($urandom_range(0, 5) == 0);
      PCSrcE      = ($urandom_range(0, 7) == 0);
      DivDoneW    = ($urandom_range(0, 4) == 0);
      DivRdW      = AW'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
